// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/ack loads and stores, stalls the pipeline while busy.
// Define MEM_ACCESS_BYTE_EN to enable sign-extended byte loads and lane-replicated byte stores.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic        byte_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  RegDst_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  WB_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] immed_o,
    output logic [4:0]  mux3_o,
    output logic [1:0]  dbg_state_o
);

`ifdef MEM_ACCESS_BYTE_EN
    localparam logic BYTE_EN = 1'b1;
`else
    localparam logic BYTE_EN = 1'b0;
`endif

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lane_q, lane_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        err_q, err_d;

    logic        access;
    logic        req_we;
    logic        req_byte;
    logic [7:0]  lane_byte;

    assign access   = valid_i & (M_i[0] | M_i[1]);
    // MemRead takes priority when both control bits are set.
    assign req_we   = M_i[0] & ~M_i[1];
    assign req_byte = BYTE_EN & byte_i;

    always_comb begin
        lane_byte = dmem_rdata_i[7:0];
        case (lane_q)
            2'd1:    lane_byte = dmem_rdata_i[15:8];
            2'd2:    lane_byte = dmem_rdata_i[23:16];
            2'd3:    lane_byte = dmem_rdata_i[31:24];
            default: lane_byte = dmem_rdata_i[7:0];
        endcase
    end

    // Handshake: dmem_req_o stays high with address/data/we/be frozen for the whole
    // WAIT state; the memory completes with a single-cycle dmem_ack_i (rdata valid
    // in that cycle). Acks seen in any other state are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        lane_d  = lane_q;
        we_d    = we_q;
        byte_d  = byte_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    addr_d  = {ALUResult_i[31:2], 2'b00};
                    we_d    = req_we;
                    byte_d  = req_byte;
                    lane_d  = ALUResult_i[1:0];
                    be_d    = req_byte ? (4'b0001 << ALUResult_i[1:0]) : 4'hF;
                    wdata_d = req_byte ? {4{WriteData_i[7:0]}} : WriteData_i;
                    cnt_d   = 16'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = byte_q ? {{24{lane_byte[7]}}, lane_byte} : dmem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            be_q    <= 4'd0;
            lane_q  <= 2'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the stall so an aborted access releases the pipeline immediately.
    assign stall_o      = ~rst_i & (((state_q == ST_IDLE) & access) | (state_q == ST_WAIT));
    assign WB_o         = stall_o ? 2'b00 : WB_i;
    assign dmem_req_o   = (state_q == ST_WAIT);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign ReadData_o   = rdata_q;
    assign err_o        = err_q;
    assign immed_o      = ALUResult_i;
    assign mux3_o       = RegDst_i;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT = 4); results scoreboarded through exp_q.
module tb_mem_access_unit;
    localparam int TO = 4;
`ifdef MEM_ACCESS_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [1:0]  WB_i;
    logic [1:0]  M_i;
    logic        byte_i;
    logic [31:0] ALUResult_i;
    logic [31:0] WriteData_i;
    logic [4:0]  RegDst_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        err_o;
    logic [1:0]  WB_o;
    logic [31:0] ReadData_o;
    logic [31:0] immed_o;
    logic [4:0]  mux3_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_bad    = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model_rd;
    logic        model_err;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .WB_i(WB_i), .M_i(M_i),
        .byte_i(byte_i), .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i),
        .RegDst_i(RegDst_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .err_o(err_o), .WB_o(WB_o), .ReadData_o(ReadData_o), .immed_o(immed_o),
        .mux3_o(mux3_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext_lane(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        b = w[8*lane +: 8];
        return {{24{b[7]}}, b};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   32'(dmem_req_o),   32'd0);
        check_eq({tag, "_we"},    32'(dmem_we_o),    32'd0);
        check_eq({tag, "_addr"},  dmem_addr_o,       32'd0);
        check_eq({tag, "_wdata"}, dmem_wdata_o,      32'd0);
        check_eq({tag, "_be"},    32'(dmem_be_o),    32'd0);
        check_eq({tag, "_rdata"}, ReadData_o,        32'd0);
        check_eq({tag, "_err"},   32'(err_o),        32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state_o),  32'd0);
    endtask

    // driver: non-memory instruction, plus a stray ack that must be ignored
    task automatic drive_nonmem(input logic [31:0] res);
        valid_i = 1'b1; M_i = 2'b00; WB_i = 2'b10; ALUResult_i = res;
        RegDst_i = 5'($urandom_range(0, 31));
        dmem_ack_i = 1'b1; dmem_rdata_i = $urandom;
        @(negedge clk_i);
        check_eq("nm_stall", 32'(stall_o),    32'd0);
        check_eq("nm_wb",    32'(WB_o),       32'd2);
        check_eq("nm_immed", immed_o,         res);
        check_eq("nm_mux3",  32'(mux3_o),     32'(RegDst_i));
        check_eq("nm_req",   32'(dmem_req_o), 32'd0);
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        check_eq("nm_rd_kept", ReadData_o,   model_rd);
        check_eq("nm_err",     32'(err_o),   32'(model_err));
        check_eq("nm_state",   32'(dbg_state_o), 32'd0);
    endtask

    // driver: one load/store; ack_at = WAIT index of the ack (negative = never)
    task automatic run_access(input logic is_store, input logic is_byte, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
        logic        byte_eff;
        logic        acked;
        int          waits_total;
        int          stalls;
        logic [31:0] exp_addr, exp_wd, exp_rd;
        logic [3:0]  exp_be;
        logic [32:0] got_exp;
        byte_eff = BYTE_EN & is_byte;
        exp_addr = {addr[31:2], 2'b00};
        exp_be   = byte_eff ? (4'b0001 << addr[1:0]) : 4'hF;
        exp_wd   = byte_eff ? {4{wd[7:0]}} : wd;
        acked    = (ack_at >= 0) && (ack_at <= TO - 1);
        waits_total = acked ? ack_at + 1 : TO;
        if (!acked)        exp_rd = 32'd0;
        else if (is_store) exp_rd = model_rd;
        else               exp_rd = byte_eff ? sext_lane(rd, addr[1:0]) : rd;
        model_rd  = exp_rd;
        model_err = model_err | ~acked;
        exp_q.push_back({model_err, exp_rd});

        valid_i = 1'b1; M_i = is_store ? 2'b01 : 2'b10; WB_i = 2'($urandom_range(1, 3));
        byte_i = is_byte; ALUResult_i = addr; WriteData_i = wd;
        RegDst_i = 5'($urandom_range(0, 31));
        @(negedge clk_i);
        check_eq("idle_stall", 32'(stall_o),    32'd1);
        check_eq("idle_wb",    32'(WB_o),       32'd0);
        check_eq("idle_req",   32'(dmem_req_o), 32'd0);
        stalls = 1;
        for (int w = 0; w < waits_total; w++) begin
            @(posedge clk_i); #1;
            dmem_ack_i   = (w == ack_at);
            dmem_rdata_i = (w == ack_at) ? rd : $urandom;
            @(negedge clk_i);
            check_eq("wait_req",   32'(dmem_req_o), 32'd1);
            check_eq("wait_we",    32'(dmem_we_o),  32'(is_store));
            check_eq("wait_addr",  dmem_addr_o,     exp_addr);
            check_eq("wait_be",    32'(dmem_be_o),  32'(exp_be));
            if (is_store) check_eq("wait_wdata", dmem_wdata_o, exp_wd);
            check_eq("wait_wb",    32'(WB_o),       32'd0);
            if (stall_o) stalls++;
        end
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
        @(negedge clk_i);
        check_eq("done_state",  32'(dbg_state_o), 32'd2);
        check_eq("done_stall",  32'(stall_o),     32'd0);
        check_eq("done_wb",     32'(WB_o),        32'(WB_i));
        check_eq("done_req",    32'(dmem_req_o),  32'd0);
        check_eq("stall_count", 32'(stalls),      32'(waits_total + 1));
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            got_exp = exp_q.pop_front();
            check_eq("sb_rdata", ReadData_o, got_exp[31:0]);
            check_eq("sb_err",   32'(err_o), 32'(got_exp[32]));
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0; M_i = 2'b00;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; WB_i = 2'b00; M_i = 2'b00; byte_i = 1'b0;
        ALUResult_i = 32'd0; WriteData_i = 32'd0; RegDst_i = 5'd0;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
        model_rd = 32'd0; model_err = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("post_rst");
        @(posedge clk_i); #1;

        drive_nonmem(32'h0000_1234);
        run_access(1'b0, 1'b0, 32'h0000_0040, 32'd0, 3, 32'hCAFE_F00D);
        run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0000_55AA, 0, 32'h0);
        run_access(1'b0, 1'b0, 32'h0000_0048, 32'd0, TO - 1, 32'h1357_9BDF);
        drive_nonmem(32'h0000_0abc);
        run_access(1'b0, 1'b0, 32'h0000_0050, 32'd0, -1, 32'h0);
        drive_nonmem(32'h0000_0def);
        run_access(1'b0, 1'b0, 32'h0000_0054, 32'd0, 1, 32'h2468_ACE0);

        // reset in the middle of an unacked load
        valid_i = 1'b1; M_i = 2'b10; WB_i = 2'b11; ALUResult_i = 32'h60;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("mid_req", 32'(dmem_req_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("arst_req",   32'(dmem_req_o), 32'd0);
        check_eq("arst_stall", 32'(stall_o),    32'd0);
        model_rd = 32'd0; model_err = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0; valid_i = 1'b0; M_i = 2'b00;
        @(negedge clk_i);
        check_reset_outputs("arst");
        @(posedge clk_i); #1;

        // byte_i is honoured only in the byte-enable build
        run_access(1'b0, 1'b1, 32'h0000_0043, 32'd0, 1, 32'h80FF_0000);
        run_access(1'b1, 1'b1, 32'h0000_0071, 32'h0000_00A5, 0, 32'h0);
        run_access(1'b0, 1'b1, 32'h0000_0062, 32'd0, 0, 32'h0012_3456);

        for (int i = 0; i < 8; i++) begin
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom_range(0, 2), $urandom);
        end
        drive_nonmem($urandom);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
